mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control unit: decodes OpCode/Funct into datapath selectors and
// sequences FETCH/DECODE/EXEC/MEM/WB. Define MC_CTRL_BUS_WAIT_EN to stall on memory readiness.
module mc_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       OpCode,
  input  logic [5:0]       Funct,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [1:0]       RegDst,
  output logic             ALUSrc,
  output logic [1:0]       DataSrc,
  output logic [1:0]       NPC_Sel,
  output logic [1:0]       ExtOp,
  output logic [2:0]       ALUOp,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd7;

  localparam logic [1:0] NPC_ADD4   = 2'd0;
  localparam logic [1:0] NPC_JUMP   = 2'd1;
  localparam logic [1:0] NPC_BRANCH = 2'd2;
  localparam logic [1:0] NPC_JR     = 2'd3;

  localparam logic [1:0] EXT_SIGNED = 2'd1;
  localparam logic [1:0] EXT_LUI    = 2'd2;

  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_LT  = 3'd3;
  localparam logic [2:0] ALU_B   = 3'd4;

  localparam logic [1:0] DST_RT = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] SRC_DM = 2'd1;
  localparam logic [1:0] SRC_PC = 2'd2;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic             r_started;
  logic [CNT_W-1:0] r_retired;

  logic w_rtype;
  logic w_nop, w_addu, w_subu, w_slt, w_jr;
  logic w_beq, w_addiu, w_ori, w_lui, w_lw, w_sw, w_j, w_jal;
  logic w_legal;
  logic w_imem_done, w_dmem_done;

  assign w_rtype = (OpCode == 6'b000000);
  assign w_nop   = w_rtype && (Funct == 6'b000000);
  assign w_addu  = w_rtype && (Funct == 6'b100001);
  assign w_subu  = w_rtype && (Funct == 6'b100011);
  assign w_slt   = w_rtype && (Funct == 6'b101010);
  assign w_jr    = w_rtype && (Funct == 6'b001000);
  assign w_beq   = (OpCode == 6'b000100);
  assign w_addiu = (OpCode == 6'b001001);
  assign w_ori   = (OpCode == 6'b001101);
  assign w_lui   = (OpCode == 6'b001111);
  assign w_lw    = (OpCode == 6'b100011);
  assign w_sw    = (OpCode == 6'b101011);
  assign w_j     = (OpCode == 6'b000010);
  assign w_jal   = (OpCode == 6'b000011);

  assign w_legal = w_nop | w_addu | w_subu | w_slt | w_jr | w_beq | w_addiu | w_ori |
                   w_lui | w_lw | w_sw | w_j | w_jal;

`ifdef MC_CTRL_BUS_WAIT_EN
  assign w_imem_done = imem_ready;
  assign w_dmem_done = dmem_ready;
`else
  logic w_unused_ready;
  assign w_unused_ready = imem_ready ^ dmem_ready;
  assign w_imem_done    = 1'b1;
  assign w_dmem_done    = 1'b1;
`endif

  // Selectors carry single-cycle meaning regardless of state; illegal words leave all at 0.
  always_comb begin
    RegDst  = 2'd0;
    ALUSrc  = 1'b0;
    DataSrc = 2'd0;
    NPC_Sel = NPC_ADD4;
    ExtOp   = 2'd0;
    ALUOp   = 3'd0;
    unique case (1'b1)
      w_subu: ALUOp = ALU_SUB;
      w_slt:  ALUOp = ALU_LT;
      w_jr:   NPC_Sel = NPC_JR;
      w_beq: begin
        ALUOp   = ALU_SUB;
        ExtOp   = EXT_SIGNED;
        NPC_Sel = zero ? NPC_BRANCH : NPC_ADD4;
      end
      w_addiu: begin
        RegDst = DST_RT;
        ALUSrc = 1'b1;
        ExtOp  = EXT_SIGNED;
      end
      w_ori: begin
        RegDst = DST_RT;
        ALUSrc = 1'b1;
        ALUOp  = ALU_OR;
      end
      w_lui: begin
        RegDst = DST_RT;
        ALUSrc = 1'b1;
        ExtOp  = EXT_LUI;
        ALUOp  = ALU_B;
      end
      w_lw: begin
        RegDst  = DST_RT;
        ALUSrc  = 1'b1;
        ExtOp   = EXT_SIGNED;
        DataSrc = SRC_DM;
      end
      w_sw: begin
        ALUSrc = 1'b1;
        ExtOp  = EXT_SIGNED;
      end
      w_j:    NPC_Sel = NPC_JUMP;
      w_jal: begin
        NPC_Sel = NPC_JUMP;
        RegDst  = DST_RA;
        DataSrc = SRC_PC;
      end
      default: ;
    endcase
  end

  // r_started holds the FSM idle until the first edge after reset release.
  always_comb begin
    w_state_nxt = r_state;
    PCWrite     = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    if (r_started) begin
      case (r_state)
        ST_FETCH: begin
          if (w_imem_done) begin
            IRWrite     = 1'b1;
            w_state_nxt = ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (!w_legal) begin
            w_state_nxt = ST_TRAP;
          end else if (w_nop || w_j) begin
            PCWrite     = 1'b1;
            w_state_nxt = ST_FETCH;
          end else if (w_jal) begin
            w_state_nxt = ST_WB;
          end else begin
            w_state_nxt = ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (w_beq || w_jr) begin
            PCWrite     = 1'b1;
            w_state_nxt = ST_FETCH;
          end else if (w_lw || w_sw) begin
            w_state_nxt = ST_MEM;
          end else begin
            w_state_nxt = ST_WB;
          end
        end
        ST_MEM: begin
          MemRead  = w_lw;
          MemWrite = w_sw;
          if (w_dmem_done) begin
            if (w_sw) begin
              PCWrite     = 1'b1;
              w_state_nxt = ST_FETCH;
            end else begin
              w_state_nxt = ST_WB;
            end
          end
        end
        ST_WB: begin
          RegWrite    = 1'b1;
          PCWrite     = 1'b1;
          w_state_nxt = ST_FETCH;
        end
        ST_TRAP: w_state_nxt = ST_TRAP;
        default: w_state_nxt = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_FETCH;
      r_started <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_started <= 1'b1;
      if (PCWrite) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  assign state   = r_state;
  assign illegal = (r_state == ST_TRAP);
  assign retired = r_retired;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl (CNT_W=8); covers both builds of MC_CTRL_BUS_WAIT_EN.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] OpCode, Funct;
  logic       zero, imem_ready, dmem_ready;
  logic       PCWrite, IRWrite, RegWrite, MemRead, MemWrite;
  logic [1:0] RegDst, DataSrc, NPC_Sel, ExtOp;
  logic       ALUSrc;
  logic [2:0] ALUOp, state;
  logic       illegal;
  logic [7:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  mc_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .Funct(Funct), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegDst(RegDst), .ALUSrc(ALUSrc), .DataSrc(DataSrc),
    .NPC_Sel(NPC_Sel), .ExtOp(ExtOp), .ALUOp(ALUOp), .state(state), .illegal(illegal),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] strobes();
    return {PCWrite, IRWrite, RegWrite, MemRead, MemWrite};
  endfunction

  initial begin
    rst_n = 1'b0; OpCode = 6'd0; Funct = 6'b100001; zero = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    tick(); tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_strobes", 32'(strobes()), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("pre_start_irwrite", 32'(IRWrite), 32'd0);

    // addu: 0,1,2,4,0
    tick();
    chk("addu_fetch", 32'(state), 32'd0);
    chk("addu_irwrite", 32'(IRWrite), 32'd1);
    tick(); chk("addu_decode", 32'(state), 32'd1);
    chk("addu_dec_strobes", 32'(strobes()), 32'd0);
    tick(); chk("addu_exec", 32'(state), 32'd2);
    tick(); chk("addu_wb", 32'(state), 32'd4);
    chk("addu_wb_strobes", 32'(strobes()), 32'b10100);
    chk("addu_regdst", 32'(RegDst), 32'd0);
    chk("addu_datasrc", 32'(DataSrc), 32'd0);
    chk("addu_aluop", 32'(ALUOp), 32'd0);
    chk("addu_ret_before", 32'(retired), 32'd0);
    tick(); chk("addu_back_fetch", 32'(state), 32'd0);
    chk("addu_regwrite_off", 32'(RegWrite), 32'd0);
    chk("addu_retired", 32'(retired), 32'd1);

    // lw with dmem_ready low
    OpCode = 6'b100011; dmem_ready = 1'b0;
    tick(); tick();
    tick(); chk("lw_mem1", 32'(state), 32'd3);
    chk("lw_memread1", 32'(MemRead), 32'd1);
`ifdef MC_CTRL_BUS_WAIT_EN
    for (int i = 0; i < 2; i++) begin
      chk("lw_pcwrite_wait", 32'(PCWrite), 32'd0);
      tick();
      chk("lw_mem_wait", 32'(state), 32'd3);
      chk("lw_memread_wait", 32'(MemRead), 32'd1);
    end
    tick();
    dmem_ready = 1'b1; #1;
    chk("lw_mem4", 32'(state), 32'd3);
    chk("lw_memread4", 32'(MemRead), 32'd1);
`endif
    tick(); chk("lw_wb", 32'(state), 32'd4);
    chk("lw_wb_strobes", 32'(strobes()), 32'b10100);
    chk("lw_datasrc", 32'(DataSrc), 32'd1);
    chk("lw_regdst", 32'(RegDst), 32'd1);
    dmem_ready = 1'b1;
    tick(); chk("lw_done", 32'(state), 32'd0);
    chk("lw_retired", 32'(retired), 32'd2);

    // beq taken, then not taken
    OpCode = 6'b000100; zero = 1'b1;
    tick(); tick(); chk("beq1_exec", 32'(state), 32'd2);
    chk("beq1_strobes", 32'(strobes()), 32'b10000);
    chk("beq1_npc", 32'(NPC_Sel), 32'd2);
    tick(); chk("beq1_retired", 32'(retired), 32'd3);
    zero = 1'b0;
    tick(); tick(); chk("beq0_exec", 32'(state), 32'd2);
    chk("beq0_strobes", 32'(strobes()), 32'b10000);
    chk("beq0_npc", 32'(NPC_Sel), 32'd0);
    tick(); chk("beq0_retired", 32'(retired), 32'd4);

    // nop, j: retire from DECODE
    OpCode = 6'd0; Funct = 6'd0;
    tick(); chk("nop_decode_strobes", 32'(strobes()), 32'b10000);
    chk("nop_npc", 32'(NPC_Sel), 32'd0);
    tick(); chk("nop_retired", 32'(retired), 32'd5);
    OpCode = 6'b000010;
    tick(); chk("j_decode_strobes", 32'(strobes()), 32'b10000);
    chk("j_npc", 32'(NPC_Sel), 32'd1);
    tick(); chk("j_retired", 32'(retired), 32'd6);

    // jal: DECODE -> WB
    OpCode = 6'b000011;
    tick(); chk("jal_decode", 32'(state), 32'd1);
    chk("jal_dec_pcwrite", 32'(PCWrite), 32'd0);
    tick(); chk("jal_wb", 32'(state), 32'd4);
    chk("jal_wb_strobes", 32'(strobes()), 32'b10100);
    chk("jal_sel", 32'({NPC_Sel, RegDst, DataSrc}), 32'b01_10_10);
    tick(); chk("jal_retired", 32'(retired), 32'd7);

    // jr
    OpCode = 6'd0; Funct = 6'b001000;
    tick(); tick(); chk("jr_exec_strobes", 32'(strobes()), 32'b10000);
    chk("jr_npc", 32'(NPC_Sel), 32'd3);
    tick(); chk("jr_retired", 32'(retired), 32'd8);

    // lui executed; then selector-only checks inside FETCH
    OpCode = 6'b001111; #1;
    chk("lui_sel", 32'({RegDst, ALUSrc, ExtOp, ALUOp}), 32'b01_1_10_100);
    tick(); tick(); tick(); chk("lui_wb", 32'(state), 32'd4);
    tick(); chk("lui_retired", 32'(retired), 32'd9);
    OpCode = 6'b001101; #1;
    chk("ori_sel", 32'({RegDst, ALUSrc, ExtOp, ALUOp}), 32'b01_1_00_010);
    OpCode = 6'b001001; #1;
    chk("addiu_sel", 32'({RegDst, ALUSrc, ExtOp, ALUOp}), 32'b01_1_01_000);
    OpCode = 6'd0; Funct = 6'b100011; #1;
    chk("subu_aluop", 32'(ALUOp), 32'd1);
    Funct = 6'b101010; #1;
    chk("slt_aluop", 32'(ALUOp), 32'd3);
    Funct = 6'b000001; #1;
    chk("badfunct_sel", 32'({RegDst, ALUSrc, DataSrc, NPC_Sel, ExtOp, ALUOp}), 32'd0);

    // sw completes from MEM
    OpCode = 6'b101011;
    tick(); tick(); tick(); chk("sw_mem", 32'(state), 32'd3);
    chk("sw_strobes", 32'(strobes()), 32'b10001);
    tick(); chk("sw_retired", 32'(retired), 32'd10);
    chk("sw_fetch", 32'(state), 32'd0);

    // illegal opcode traps
    OpCode = 6'b111111;
    tick(); chk("trap_decode", 32'(state), 32'd1);
    chk("trap_dec_strobes", 32'(strobes()), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      imem_ready = i[0]; dmem_ready = ~i[0]; #1;
      chk("trap_hold", 32'({state, illegal, strobes()}), 32'b111_1_00000);
    end
    chk("trap_retired", 32'(retired), 32'd10);
    imem_ready = 1'b1; dmem_ready = 1'b1;
    rst_n = 1'b0; #1;
    chk("trap_rst_state", 32'({state, illegal}), 32'd0);
    chk("trap_rst_retired", 32'(retired), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    OpCode = 6'd0; Funct = 6'd0;
    tick(); chk("restart_fetch", 32'({state, IRWrite}), 32'b000_1);

    // counter wrap with nops
    for (int i = 0; i < 255; i++) begin
      tick(); tick();
    end
    chk("wrap_255", 32'(retired), 32'd255);
    tick(); tick();
    chk("wrap_0", 32'(retired), 32'd0);

    // asynchronous reset mid-MEM of sw
    OpCode = 6'b101011;
    tick(); tick(); tick(); chk("sw2_mem", 32'({state, MemWrite}), 32'b011_1);
    chk("sw2_retired_pre", 32'(retired), 32'd0);
    #2 rst_n = 1'b0; #1;
    chk("async_memwrite", 32'(MemWrite), 32'd0);
    chk("async_state", 32'(state), 32'd0);
    chk("async_strobes", 32'(strobes()), 32'd0);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
